// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Fetch-stage sequencer for a single-port, combinational-read program memory
//   holding a mix of 32-bit and 16-bit (RVC) instructions at halfword alignment.
//   One memory word is read per cycle. A 16-bit residual buffer holds the upper
//   half of the last word so that a 32-bit instruction straddling two words can
//   be assembled. One aligned instruction is emitted per valid/ready handshake.
//
// Build option:
//   LOADER_EN - adds a program loader port that takes over the memory port
//               (write) while load_valid is high and freezes fetch.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   redirect_valid/pc   PC redirect from branch/jump resolution (bit 0 ignored)
//   mem_byte_address    word-aligned byte address to program memory
//   mem_read_data       combinational read data for mem_byte_address
//   mem_write_enable    program memory write strobe (loader only)
//   mem_write_data      program memory write data (loader only)
//   instr_valid/ready   handshake towards decode
//   instr_data          instruction, 16-bit ones zero-extended
//   instr_pc            PC of instr_data
//   instr_compressed    1 = 16-bit instruction
//   load_valid/addr/data/ready  loader port (LOADER_EN only)

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_byte_address,
  input  logic [31:0] mem_read_data,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
`ifdef LOADER_EN
  input  logic        load_valid,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        load_ready,
`endif
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_compressed
);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_ALIGN = 1'b1
  } state_t;

  // Fetch addresses wrap at the memory size.
  localparam logic [31:0] ADDR_MASK = 32'(4 * MEM_WORDS) - 32'd1;
  localparam logic [31:0] PC_RESET  = RESET_PC & 32'hFFFF_FFFE;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] buf_q, buf_d;
  logic        buf_vld_q, buf_vld_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [31:0] ipc_q, ipc_d;
  logic        comp_q, comp_d;

  logic        adv;
  logic [29:0] fetch_word;

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    buf_d            = buf_q;
    buf_vld_d        = buf_vld_q;
    valid_d          = valid_q;
    data_d           = data_q;
    ipc_d            = ipc_q;
    comp_d           = comp_q;
    adv              = !valid_q || instr_ready;

    // With a buffered low half, the rest of the instruction lives in the next word.
    fetch_word       = buf_vld_q ? (pc_q[31:2] + 30'd1) : pc_q[31:2];
    mem_byte_address = {fetch_word, 2'b00} & ADDR_MASK;
    mem_write_enable = 1'b0;
    mem_write_data   = 32'h0;

`ifdef LOADER_EN
    load_ready = load_valid;
    if (load_valid) begin
      mem_write_enable = 1'b1;
      mem_byte_address = load_addr & 32'hFFFF_FFFC;
      mem_write_data   = load_data;
    end
`endif

    if (redirect_valid) begin
      pc_d      = redirect_pc & 32'hFFFF_FFFE;
      buf_vld_d = 1'b0;
      valid_d   = 1'b0;
      state_d   = redirect_pc[1] ? ST_ALIGN : ST_FETCH;
    end
`ifdef LOADER_EN
    else if (load_valid) begin
      // The loader may overwrite the word the buffer came from: drop it and
      // refetch, which needs an ALIGN pass when pc sits on an odd halfword.
      buf_vld_d = 1'b0;
      state_d   = pc_q[1] ? ST_ALIGN : ST_FETCH;
    end
`endif
    else if (adv) begin
      case (state_q)
        ST_ALIGN: begin
          buf_d     = mem_read_data[31:16];
          buf_vld_d = 1'b1;
          valid_d   = 1'b0;
          state_d   = ST_FETCH;
        end
        default: begin
          valid_d = 1'b1;
          ipc_d   = pc_q;
          if (!buf_vld_q) begin
            if (mem_read_data[1:0] != 2'b11) begin
              data_d    = {16'h0, mem_read_data[15:0]};
              comp_d    = 1'b1;
              buf_d     = mem_read_data[31:16];
              buf_vld_d = 1'b1;
              pc_d      = pc_q + 32'd2;
            end else begin
              data_d    = mem_read_data;
              comp_d    = 1'b0;
              pc_d      = pc_q + 32'd4;
            end
          end else if (buf_q[1:0] != 2'b11) begin
            // Buffered compressed instruction: memory data not consumed.
            data_d    = {16'h0, buf_q};
            comp_d    = 1'b1;
            buf_vld_d = 1'b0;
            pc_d      = pc_q + 32'd2;
          end else begin
            data_d    = {mem_read_data[15:0], buf_q};
            comp_d    = 1'b0;
            buf_d     = mem_read_data[31:16];
            buf_vld_d = 1'b1;
            pc_d      = pc_q + 32'd4;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= PC_RESET[1] ? ST_ALIGN : ST_FETCH;
      pc_q      <= PC_RESET;
      buf_q     <= 16'h0;
      buf_vld_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= 32'h0;
      ipc_q     <= 32'h0;
      comp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      ipc_q     <= ipc_d;
      comp_q    <= comp_d;
    end
  end

  assign instr_valid      = valid_q;
  assign instr_data       = data_q;
  assign instr_pc         = ipc_q;
  assign instr_compressed = comp_q;

endmodule
